// File: rtl/uart_rx_byte.sv
// UART receiver: async 8N1 serial line into a one-entry byte holding register with valid/ready.
// Define UART_RX_PARITY_EN for 8E1 framing with the parity_err pulse output.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun_err
`ifdef UART_RX_PARITY_EN
  ,output logic      parity_err
`endif
);

  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TICK_W-1:0] HALF_LOAD = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LOAD = TICK_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        sync_q;
  logic              rx_s;
  logic [TICK_W-1:0] tick;
  logic              tick_zero;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              byte_ok_p1;

  logic              tick_load;
  logic [TICK_W-1:0] tick_val;
  logic              clr_idx;
  logic              sample_bit;
  logic              stop_good;
  logic              stop_bad;
`ifdef UART_RX_PARITY_EN
  logic              sample_par;
  logic              stop_par_bad;
  logic              par_bad;
`endif

  // rx is asynchronous to clk: two-flop synchroniser, reset to the idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  assign rx_s      = sync_q[1];
  assign tick_zero = (tick == '0);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!rx_s) state_nxt = S_START;
      S_START:  if (tick_zero) state_nxt = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (tick_zero && bit_idx == 3'd7) state_nxt = S_PARITY;
`else
      S_DATA:   if (tick_zero && bit_idx == 3'd7) state_nxt = S_STOP;
`endif
      S_PARITY: if (tick_zero) state_nxt = S_STOP;
      S_STOP:   if (tick_zero) state_nxt = rx_s ? S_IDLE : S_BREAK;
      S_BREAK:  if (rx_s) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tick_load  = 1'b0;
    tick_val   = FULL_LOAD;
    clr_idx    = 1'b0;
    sample_bit = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    sample_par   = 1'b0;
    stop_par_bad = 1'b0;
`endif
    case (state)
      S_IDLE: if (!rx_s) begin
        tick_load = 1'b1;
        tick_val  = HALF_LOAD;
        clr_idx   = 1'b1;
      end
      S_START: if (tick_zero && !rx_s) tick_load = 1'b1;
      S_DATA: if (tick_zero) begin
        tick_load  = 1'b1;
        sample_bit = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (tick_zero) begin
        tick_load  = 1'b1;
        sample_par = 1'b1;
      end
`endif
      S_STOP: if (tick_zero) begin
`ifdef UART_RX_PARITY_EN
        stop_good    = rx_s && !par_bad;
        stop_par_bad = rx_s && par_bad;
`else
        stop_good    = rx_s;
`endif
        stop_bad     = !rx_s;
      end
      default: ;
    endcase
  end

  // Shift register carries no reset: it is only read after eight fresh samples
  always_ff @(posedge clk) begin
    if (sample_bit) shift <= {rx_s, shift[7:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick       <= '0;
      bit_idx    <= 3'd0;
      byte_ok_p1 <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (tick_load)       tick <= tick_val;
      else if (!tick_zero) tick <= tick - 1'b1;
      if (clr_idx)         bit_idx <= 3'd0;
      else if (sample_bit) bit_idx <= bit_idx + 3'd1;
      byte_ok_p1 <= stop_good;
      frame_err  <= stop_bad;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (sample_par) par_bad <= (rx_s != ^shift);
      parity_err <= stop_par_bad;
    end
  end
`endif

  // ---- delivery stage: one cycle after the good stop sample ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (byte_ok_p1) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 87 clk/bit; monitor counts DUT pulses, checks use fixed expectations.
`timescale 1ns/1ps
module tb_uart_rx_byte;
  localparam int CPB = 87;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       busy;
  logic       frame_err;
  logic       overrun_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
`ifdef UART_RX_PARITY_EN
    ,.parity_err(parity_err)
`endif
  );

  always #50 clk = ~clk;

  // Event monitor: counts valid rises and error pulses, captures the byte at each valid rise
  int         n_vld = 0;
  int         n_fe  = 0;
  int         n_ov  = 0;
  int         n_pe  = 0;
  logic [7:0] last_data = 8'h00;
  logic       vld_d = 1'b0;

  always @(negedge clk) begin
    vld_d <= rx_valid;
    if (rx_valid && !vld_d) begin
      n_vld     <= n_vld + 1;
      last_data <= rx_data;
    end
    if (frame_err)   n_fe <= n_fe + 1;
    if (overrun_err) n_ov <= n_ov + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err)  n_pe <= n_pe + 1;
`endif
  end

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop_b);
  endtask

  int b_vld, b_fe, b_ov, b_pe;

  task automatic snap();
    b_vld = n_vld;
    b_fe  = n_fe;
    b_ov  = n_ov;
    b_pe  = n_pe;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk_eq("rst_rx_valid", int'(rx_valid), 0);
    chk_eq("rst_rx_data", int'(rx_data), 0);
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_frame_err", int'(frame_err), 0);
    chk_eq("rst_overrun_err", int'(overrun_err), 0);
    rst_n = 1'b1;
    wait_cyc(10);

    // 1: plain byte 0x55
    rx_ready = 1'b1;
    snap();
    send_frame(8'h55, 1'b1);
    wait_cyc(0);
    chk_eq("t1_latency_valid", n_vld - b_vld, 1);
    wait_cyc(20);
    chk_eq("t1_data", int'(last_data), 8'h55);
    chk_eq("t1_fe", n_fe - b_fe, 0);
    chk_eq("t1_ov", n_ov - b_ov, 0);
    chk_eq("t1_busy", int'(busy), 0);
    chk_eq("t1_valid_consumed", int'(rx_valid), 0);

    // 2: false start glitch
    snap();
    rx = 1'b0;
    wait_cyc(10);
    chk_eq("t2_busy_in_start", int'(busy), 1);
    wait_cyc(20);
    rx = 1'b1;
    wait_cyc(45);
    chk_eq("t2_busy_after", int'(busy), 0);
    chk_eq("t2_no_valid", n_vld - b_vld, 0);
    chk_eq("t2_no_fe", n_fe - b_fe, 0);

    // 3: framing error, break hold, recovery
    snap();
    send_frame(8'hA5, 1'b0);
    wait_cyc(300);
    chk_eq("t3_busy_break", int'(busy), 1);
    chk_eq("t3_fe_once", n_fe - b_fe, 1);
    chk_eq("t3_no_valid", n_vld - b_vld, 0);
    rx = 1'b1;
    wait_cyc(2 * CPB);
    chk_eq("t3_busy_idle", int'(busy), 0);
    send_frame(8'h3C, 1'b1);
    wait_cyc(20);
    chk_eq("t3_valid_3c", n_vld - b_vld, 1);
    chk_eq("t3_data_3c", int'(last_data), 8'h3C);
    chk_eq("t3_fe_total", n_fe - b_fe, 1);

    // 4: overrun with consumer stalled
    rx_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_cyc(20);
    chk_eq("t4_valid_held", int'(rx_valid), 1);
    chk_eq("t4_data_held", int'(rx_data), 8'h11);
    chk_eq("t4_ov_once", n_ov - b_ov, 1);
    chk_eq("t4_valid_rises", n_vld - b_vld, 1);
    chk_eq("t4_no_fe", n_fe - b_fe, 0);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("t4_valid_drop", int'(rx_valid), 0);
    wait_cyc(5);
    chk_eq("t4_ov_total", n_ov - b_ov, 1);

    // 5: reset during DATA bit 3, then recover
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    wait_cyc(10);
    chk_eq("t5_pre_valid", int'(rx_valid), 1);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1 & (8'h99 >> i));
    rx = 1'b1;
    wait_cyc(40);
    chk_eq("t5_busy_mid", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_eq("t5_rst_valid", int'(rx_valid), 0);
    chk_eq("t5_rst_data", int'(rx_data), 0);
    chk_eq("t5_rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rx_ready = 1'b1;
    wait_cyc(2 * CPB);
    snap();
    send_frame(8'hF0, 1'b1);
    wait_cyc(20);
    chk_eq("t5_valid_f0", n_vld - b_vld, 1);
    chk_eq("t5_data_f0", int'(last_data), 8'hF0);
    chk_eq("t5_no_fe", n_fe - b_fe, 0);

`ifdef UART_RX_PARITY_EN
    // 6: parity mismatch discards, correct parity delivers
    snap();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    wait_cyc(20);
    chk_eq("t6_pe_once", n_pe - b_pe, 1);
    chk_eq("t6_no_valid", n_vld - b_vld, 0);
    chk_eq("t6_no_fe", n_fe - b_fe, 0);
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    wait_cyc(20);
    chk_eq("t6_valid_07", n_vld - b_vld, 1);
    chk_eq("t6_data_07", int'(last_data), 8'h07);
    chk_eq("t6_pe_total", n_pe - b_pe, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
